// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED mode scheduler and its button front end.
package led_sched_pkg;

  localparam int unsigned LED_W = 4;
  localparam int unsigned SW_W  = 4;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    BLANK  = 2'd2
  } state_e;

  // Bit offset of mode m's slice inside the packed generator bus.
  function automatic int unsigned mode_lsb(input int unsigned m);
    return m * LED_W;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and registered rising-edge pulse
// for one asynchronous push-button.
module btn_debounce
  import led_sched_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int unsigned CNT_W    = cnt_width(STABLE_CYCLES);
  localparam int unsigned CNT_LAST = (STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0;

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles the synced level differs from the accepted one.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(CNT_LAST)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// Chooses which pattern generator drives the LEDs: switch-selected in manual,
// dwell/button rotation in auto, with an all-off window after each change.
module led_mode_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_MODES       = 5,
  parameter int unsigned SEL_W           = 3,
  parameter int unsigned DWELL_CYCLES    = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLANK_CYCLES    = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SW_W-1:0]              SW,
  input  logic                         btn_next,
  input  logic [LED_W*NUM_MODES-1:0]   pattern_in,
  output logic [LED_W-1:0]             LED,
  output logic [SEL_W-1:0]             mode,
  output logic                         mode_change
);

  localparam int unsigned DW_W       = cnt_width(DWELL_CYCLES);
  localparam int unsigned BL_W       = cnt_width(BLANK_CYCLES);
  localparam int unsigned DWELL_LAST = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [SEL_W-1:0] PASS_MODE = SEL_W'(NUM_MODES);
  localparam logic [SEL_W-1:0] LAST_MODE = SEL_W'(NUM_MODES - 1);

  logic [SW_W-1:0]  sw_s1_q;
  logic [SW_W-1:0]  sw_s2_q;
  logic             btn_step;
  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] mode_q;
  logic [SEL_W-1:0] mode_d;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] mode_step;
  logic             mode_change_q;
  logic             mode_change_d;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic [DW_W-1:0]  dwell_q;
  logic [DW_W-1:0]  dwell_d;
  logic [BL_W-1:0]  blank_q;
  logic [BL_W-1:0]  blank_d;
  logic             auto_en;

  btn_debounce #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next),
    .btn_rise(btn_step)
  );

  assign auto_en = sw_s2_q[SW_W-1];

  // Manual target: out-of-range selections fall back to switch passthrough.
  always_comb begin
    target = PASS_MODE;
    if (32'(sw_s2_q[2:0]) < NUM_MODES) begin
      target = SEL_W'(sw_s2_q[2:0]);
    end
  end

  // Auto rotation; passthrough steps to mode 0 like the last generator does.
  always_comb begin
    mode_step = mode_q + SEL_W'(1);
    if (mode_q >= LAST_MODE) begin
      mode_step = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    dwell_d       = '0;
    blank_d       = '0;
    case (state_q)
      MANUAL: begin
        if (target != mode_q) begin
          mode_d        = target;
          mode_change_d = 1'b1;
          if (BLANK_CYCLES != 0) begin
            state_d = BLANK;
          end
        end else if (auto_en) begin
          state_d = AUTO;
        end
      end
      AUTO: begin
        // Leaving auto outranks any step due in the same cycle.
        if (!auto_en) begin
          state_d = MANUAL;
        end else if ((dwell_q == DW_W'(DWELL_LAST)) || btn_step) begin
          mode_d        = mode_step;
          mode_change_d = 1'b1;
          if (BLANK_CYCLES != 0) begin
            state_d = BLANK;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      BLANK: begin
        if (blank_q == BL_W'(BLANK_LAST)) begin
          state_d = auto_en ? AUTO : MANUAL;
        end else begin
          blank_d = blank_q + BL_W'(1);
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase
  end

  // LED follows the next state so the old pattern never leaks past a change.
  always_comb begin
    led_d = '0;
    if (state_d != BLANK) begin
      if (mode_d == PASS_MODE) begin
        led_d = sw_s2_q;
      end else begin
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
          if (mode_d == SEL_W'(k)) begin
            led_d = pattern_in[mode_lsb(k) +: LED_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      state_q       <= MANUAL;
      mode_q        <= '0;
      mode_change_q <= 1'b0;
      led_q         <= '0;
      dwell_q       <= '0;
      blank_q       <= '0;
    end else begin
      sw_s1_q       <= SW;
      sw_s2_q       <= sw_s1_q;
      state_q       <= state_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
      led_q         <= led_d;
      dwell_q       <= dwell_d;
      blank_q       <= blank_d;
    end
  end

  assign LED         = led_q;
  assign mode        = mode_q;
  assign mode_change = mode_change_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with short dwell/debounce/blank timing.
module tb_led_mode_scheduler;

  localparam int unsigned NUM_MODES = 5;
  localparam int unsigned SEL_W     = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             SW;
  logic                   btn_next;
  logic [4*NUM_MODES-1:0] pattern_in;
  logic [3:0]             LED;
  logic [SEL_W-1:0]       mode;
  logic                   mode_change;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rst;
    logic [3:0]       sw;
    logic             btn;
    int               ticks;
    logic [3:0]       led;
    logic [SEL_W-1:0] mode;
    logic             mc;
  } vec_t;

  vec_t vecs[$];

  led_mode_scheduler #(
    .NUM_MODES      (NUM_MODES),
    .SEL_W          (SEL_W),
    .DWELL_CYCLES   (20),
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SW         (SW),
    .btn_next   (btn_next),
    .pattern_in (pattern_in),
    .LED        (LED),
    .mode       (mode),
    .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] sw, input logic b,
                              input int t, input logic [3:0] led,
                              input logic [SEL_W-1:0] m, input logic mc);
    vec_t v;
    v.rst = r; v.sw = sw; v.btn = b; v.ticks = t;
    v.led = led; v.mode = m; v.mc = mc;
    return v;
  endfunction

  // Drive inputs, advance the given number of clocks, sample 1 ns after the edge.
  task automatic run(input string tag, input int idx, input vec_t v);
    rst      = v.rst;
    SW       = v.sw;
    btn_next = v.btn;
    repeat (v.ticks) @(posedge clk);
    #1;
    checks++;
    if (LED !== v.led) begin
      errors++;
      $display("FAIL %s[%0d] LED got %h want %h", tag, idx, LED, v.led);
    end
    checks++;
    if (mode !== v.mode) begin
      errors++;
      $display("FAIL %s[%0d] mode got %0d want %0d", tag, idx, mode, v.mode);
    end
    checks++;
    if (mode_change !== v.mc) begin
      errors++;
      $display("FAIL %s[%0d] mode_change got %b want %b", tag, idx, mode_change, v.mc);
    end
  endtask

  initial begin
    pattern_in = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    rst        = 1'b1;
    SW         = 4'b0010;
    btn_next   = 1'b0;

    // Reset, manual select, passthrough, auto wrap, debounce.
    vecs.push_back(mk(1, 4'b0010, 0,  2, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 4'b0010, 0,  3, 4'h0, 3'd2, 1));
    vecs.push_back(mk(0, 4'b0010, 0,  1, 4'h0, 3'd2, 0));
    vecs.push_back(mk(0, 4'b0010, 0,  1, 4'h0, 3'd2, 0));
    vecs.push_back(mk(0, 4'b0010, 0,  1, 4'h3, 3'd2, 0));
    vecs.push_back(mk(0, 4'b0110, 0,  3, 4'h0, 3'd5, 1));
    vecs.push_back(mk(0, 4'b0110, 0,  2, 4'h0, 3'd5, 0));
    vecs.push_back(mk(0, 4'b0110, 0,  1, 4'h6, 3'd5, 0));
    vecs.push_back(mk(0, 4'b0111, 0,  2, 4'h6, 3'd5, 0));
    vecs.push_back(mk(0, 4'b0111, 0,  1, 4'h7, 3'd5, 0));
    vecs.push_back(mk(0, 4'b0101, 0,  3, 4'h5, 3'd5, 0));
    vecs.push_back(mk(0, 4'b0100, 0,  3, 4'h0, 3'd4, 1));
    vecs.push_back(mk(0, 4'b0100, 0,  3, 4'h5, 3'd4, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  3, 4'h5, 3'd4, 0));
    vecs.push_back(mk(0, 4'b1100, 0, 19, 4'h5, 3'd4, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd0, 1));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 1,  1, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 1,  2, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 1,  3, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0, 11, 4'h1, 3'd0, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd1, 1));
    vecs.push_back(mk(0, 4'b1100, 0,  3, 4'h2, 3'd1, 0));
    vecs.push_back(mk(0, 4'b1100, 1,  4, 4'h2, 3'd1, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  2, 4'h2, 3'd1, 0));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd2, 1));
    vecs.push_back(mk(0, 4'b1100, 0,  3, 4'h3, 3'd2, 0));
    vecs.push_back(mk(0, 4'b1100, 1, 20, 4'h4, 3'd3, 0));
    vecs.push_back(mk(0, 4'b1100, 1, 79, 4'h0, 3'd2, 1));
    vecs.push_back(mk(0, 4'b1100, 0,  1, 4'h0, 3'd2, 0));

    foreach (vecs[i]) run("vec", i, vecs[i]);

    // Button step lands on the dwell terminal cycle: one step only.
    run("simul", 0, mk(0, 4'b1100, 0, 15, 4'h3, 3'd2, 0));
    run("simul", 1, mk(0, 4'b1100, 1,  4, 4'h3, 3'd2, 0));
    run("simul", 2, mk(0, 4'b1100, 0,  2, 4'h3, 3'd2, 0));
    run("simul", 3, mk(0, 4'b1100, 0,  1, 4'h0, 3'd3, 1));
    run("simul", 4, mk(0, 4'b1100, 0,  1, 4'h0, 3'd3, 0));
    run("simul", 5, mk(0, 4'b1100, 0,  2, 4'h4, 3'd3, 0));

    // Auto disable lands on the dwell terminal cycle: manual wins, no step.
    run("autooff", 0, mk(0, 4'b1100, 0, 17, 4'h4, 3'd3, 0));
    run("autooff", 1, mk(0, 4'b0011, 0,  3, 4'h4, 3'd3, 0));
    run("autooff", 2, mk(0, 4'b0011, 0,  5, 4'h4, 3'd3, 0));

    // Reset in the middle of a blanking window.
    run("rstblank", 0, mk(0, 4'b0001, 0,  3, 4'h0, 3'd1, 1));
    run("rstblank", 1, mk(0, 4'b0001, 0,  1, 4'h0, 3'd1, 0));
    run("rstblank", 2, mk(1, 4'b0001, 0,  1, 4'h0, 3'd0, 0));
    run("rstblank", 3, mk(0, 4'b0000, 0,  6, 4'h1, 3'd0, 0));

    // Reset mid-dwell with a debounced press about to be consumed.
    run("rstdwell", 0, mk(0, 4'b1000, 0,  3, 4'h1, 3'd0, 0));
    run("rstdwell", 1, mk(0, 4'b1000, 1,  4, 4'h1, 3'd0, 0));
    run("rstdwell", 2, mk(0, 4'b1000, 0,  2, 4'h1, 3'd0, 0));
    run("rstdwell", 3, mk(1, 4'b1000, 0,  1, 4'h0, 3'd0, 0));
    run("rstdwell", 4, mk(0, 4'b1000, 0, 10, 4'h1, 3'd0, 0));
    run("rstdwell", 5, mk(0, 4'b1000, 0, 13, 4'h0, 3'd1, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_scheduler.md
Name: led_mode_scheduler

Overview:
Controller that decides which LED pattern generator drives the 4 board LEDs.
- Manual mode: the mode follows the slide switches.
- Auto mode: the mode rotates through all generators on a dwell timer, and a debounced push-button steps it early.
- Every mode change inserts a short all-off blanking window.
- Sits between the pattern generators (each a 4-bit output on the same clk) and the LED pins; replaces the purely combinational switch mux.

Parameters:
- NUM_MODES, 5, number of pattern generators; modes 0..NUM_MODES-1.
- SEL_W, 3, mode index width; must satisfy 2**SEL_W > NUM_MODES.
- DWELL_CYCLES, 100_000_000, clk cycles per mode in auto (1 s at 100 MHz).
- DEBOUNCE_CYCLES, 1_000_000, cycles the button must be stable before it is accepted.
- BLANK_CYCLES, 5_000_000, cycles LEDs are held at 0 after a mode change; 0 disables blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- SW  in  4  raw slide switches; SW[3]=auto enable, SW[2:0]=manual mode select.
- btn_next  in  1  raw push-button, active-high, asynchronous to clk.
- pattern_in  in  4*NUM_MODES  generator outputs; mode k occupies bits [4k+3:4k].
- LED  out  4  registered LED drive.
- mode  out  SEL_W  current mode index; value NUM_MODES means switch passthrough.
- mode_change  out  1  one-cycle pulse on the cycle the mode register updates.

Behaviour:
- Reset (rst=1 at a clk edge) clears every register. Resulting outputs: LED=0, mode=0, mode_change=0, state=MANUAL. All counters and synchronizer flops go to 0.
- Input sync: SW and btn_next each pass through 2 flops; all logic uses only the synced values.
- Debounce: the synced button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates. btn_step is a 1-cycle pulse on a debounced 0->1 edge only.
- FSM states: MANUAL, AUTO, BLANK.
  - MANUAL: target = SW[2:0] if < NUM_MODES, else NUM_MODES (passthrough). If target != mode, load mode, pulse mode_change, enter BLANK. If synced SW[3]=1, enter AUTO with the dwell counter cleared; mode is unchanged.
  - AUTO: the dwell counter increments each cycle. A step occurs when it reaches DWELL_CYCLES-1 or btn_step=1.
    - If both occur in the same cycle, only one step is taken.
    - Step: mode = (mode+1) wraps from NUM_MODES-1 to 0. The counter clears, mode_change pulses, enter BLANK.
    - If mode==NUM_MODES on entry to AUTO, the first step goes to 0.
    - SW[3]=0 leads to MANUAL, which is higher priority than a step in the same cycle.
  - BLANK: the blank counter counts to BLANK_CYCLES-1, then returns to the originating state (AUTO if SW[3]=1, else MANUAL). The dwell counter is held at 0.
    - btn_step is ignored in BLANK.
    - SW changes are evaluated only after return to MANUAL.
    - If BLANK_CYCLES=0, BLANK is skipped and the FSM moves straight to the next state.
- LED register: 0 while in BLANK. Otherwise LED = pattern_in slice[mode], or synced SW when mode==NUM_MODES. Latency is 1 cycle from mode/pattern to LED.
- mode_change asserts in the same cycle the mode register takes its new value.
- Reset mid-count or mid-BLANK aborts immediately; no pending step survives.
- Counter widths are $clog2 of their parameter. They must never overflow or wrap past their terminal value.

Decomposition:
- Package led_sched_pkg: state enum (MANUAL, AUTO, BLANK); LED_W=4 constant; helper function for the mode-slice index.
- Sub-module btn_debounce (2-flop sync, stability counter, rising-edge pulse). It is reused for future buttons.
- Everything else stays in led_mode_scheduler.

Test Plan:
Benches override DWELL_CYCLES=20, DEBOUNCE_CYCLES=4, BLANK_CYCLES=3, NUM_MODES=5, and set pattern_in slice k = k+1.
1. Reset: hold rst 2 cycles with SW=4'b0010 -> LED=0, mode=0, mode_change=0. After release: mode=2 with a mode_change pulse, LED=0 for 3 cycles, then LED=4'h3.
2. Manual passthrough: SW=4'b0110 -> mode=5; after blanking, LED=4'h6 and it tracks SW[3:0] with 1-cycle latency (after the 2-flop sync).
3. Auto wrap: SW[3]=1 from mode 4 -> after 20 cycles mode=0, mode_change=1 for exactly 1 cycle; LED=0 for 3 cycles, then 4'h1.
4. Debounce: btn_next glitches of 1-3 cycles -> no step. Held 4+ cycles -> exactly one step. A press held for 100 cycles -> only one step.
5. Simultaneous: btn_step lands on the dwell terminal cycle -> mode advances by 1, not 2. A step landing on the same cycle SW[3] falls -> MANUAL, no step.
6. Reset mid-BLANK and mid-dwell -> next cycle all outputs reset; no stale step after release.
